// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge.
// Each accepted single AHB transfer becomes one APB SETUP+ACCESS sequence;
// AHB wait states are inserted until PREADY. PSLVERR and misaligned or
// oversize requests are answered with the two-cycle AHB ERROR response.
//
// Handshake semantics: on the AHB side a data phase completes on the cycle
// HREADYOUT=1, with HRESP qualifying it (HRESP=1 and HREADYOUT=0 is the first
// ERROR cycle). On the APB side an access completes on the cycle
// PSEL & PENABLE & PREADY; PSLVERR and PRDATA are only meaningful then.
module ahb_apb_bridge #(
    parameter int PADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic               HWRITE,
    input  logic [3:0]         HPROT,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    output logic [PADDR_W-1:0] PADDR,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    output logic [3:0]         PSTRB,
    output logic [2:0]         PPROT,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [PADDR_W-1:0]   paddr_q, paddr_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [2:0]           pprot_q, pprot_d;

    logic                 accept;
    logic                 misaligned;
    logic [3:0]           strb_new;
    logic                 unused_inputs;

    // A transfer is taken only when the address phase actually ends on the bus.
    assign accept = HSEL & HTRANS[1] & HREADY;

    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                        (HSIZE > 3'd2);

    // Upper address bits, SEQ/NONSEQ distinction and cacheable/bufferable are
    // irrelevant on a single APB segment.
    assign unused_inputs = ^{HTRANS[0], HADDR[31:PADDR_W], HPROT[3:2]};

    // Byte lanes of the request being presented in the address phase.
    always_comb begin
        strb_new = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    strb_new = 4'b0001 << HADDR[1:0];
                3'd1:    strb_new = HADDR[1] ? 4'b1100 : 4'b0011;
                3'd2:    strb_new = 4'b1111;
                default: strb_new = 4'b0000;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    state_d = misaligned ? S_ERR1 : S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = S_ERR1;
                    end else if (accept) begin
                        state_d = misaligned ? S_ERR1 : S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from state and the live APB response.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        case (state_q)
            S_SETUP:  HREADYOUT = 1'b0;
            S_ACCESS: begin
                HREADYOUT = PREADY & ~PSLVERR;
                HRDATA    = PRDATA;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b0;
            end
        endcase
    end

    // Next values of the registered APB signals; request fields load only when
    // a fresh transfer enters SETUP, so they stay stable through ACCESS.
    always_comb begin
        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        if (state_d == S_SETUP) begin
            paddr_d  = HADDR[PADDR_W-1:0];
            pwrite_d = HWRITE;
            pstrb_d  = strb_new;
            pprot_d  = {~HPROT[0], 1'b0, HPROT[1]};
        end
    end

    // Registered APB signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pstrb_q   <= 4'b0000;
            pprot_q   <= 3'b000;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    // The master holds HWDATA through wait states, so it is valid from SETUP on.
    assign PWDATA    = HWDATA;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: an AHB master driver, an APB slave
// model with per-transfer wait states / error / read data, and two monitors
// comparing against expectation queues filled when stimulus is issued.
`timescale 1ns/1ps
module tb_ahb_apb_bridge;
  localparam int PADDR_W = 16;

  logic               clk;
  logic               rst;
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [2:0]         HSIZE;
  logic               HWRITE;
  logic [3:0]         HPROT;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [31:0]        HRDATA;
  logic               HRESP;
  logic [PADDR_W-1:0] PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [3:0]         PSTRB;
  logic [2:0]         PPROT;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;
  logic [2:0]         dbg_state;

  // single slave on the bus: bus-wide HREADY is the bridge's own HREADYOUT
  assign HREADY = HREADYOUT;

  ahb_apb_bridge #(.PADDR_W(PADDR_W)) dut (
    .clk(clk), .rst(rst),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- transfer description ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic [7:0]  waits;   // PREADY-low cycles the slave inserts
    logic        slverr;
    logic [31:0] rdata;
    logic [3:0]  gap;     // idle cycles before the next transfer
  } xfer_t;

  xfer_t       stim_q[$];
  xfer_t       beh_q[$];       // slave behaviour, consumed per APB access
  logic [41:0] exp_q[$];       // {err, is_read, rdata, low_cycles}
  logic [55:0] apb_exp_q[$];   // {paddr, pwrite, pstrb, pprot, pwdata}

  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic misaligned(input xfer_t x);
    if (x.size > 3'd2) return 1'b1;
    return (x.addr % (32'd1 << x.size)) != 32'd0;
  endfunction

  function automatic logic [3:0] exp_strb(input xfer_t x);
    int nbytes;
    int mask;
    if (!x.write) return 4'b0000;
    nbytes = 1 << x.size;
    mask   = ((1 << nbytes) - 1) << (x.addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [2:0] exp_prot(input xfer_t x);
    return {~x.prot[0], 1'b0, x.prot[1]};
  endfunction

  function automatic logic [41:0] exp_ahb(input xfer_t x);
    logic       err;
    logic [7:0] low;
    if (misaligned(x)) begin
      err = 1'b1; low = 8'd1;                // ERR1 only
    end else if (x.slverr) begin
      err = 1'b1; low = x.waits + 8'd3;      // SETUP, waits, failing ACCESS, ERR1
    end else begin
      err = 1'b0; low = x.waits + 8'd1;      // SETUP, waits
    end
    return {err, ~x.write, x.rdata, low};
  endfunction

  function automatic xfer_t mk(input logic [31:0] addr, input logic [2:0] size,
                               input logic write, input logic [31:0] wdata,
                               input int waits, input logic slverr,
                               input logic [31:0] rdata, input int gap);
    xfer_t x;
    x.addr = addr; x.size = size; x.write = write;
    x.prot = 4'($urandom_range(0, 15));
    x.wdata = wdata; x.waits = 8'(waits); x.slverr = slverr;
    x.rdata = rdata; x.gap = 4'(gap);
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int    r;
    r = $urandom_range(0, 9);
    x.size  = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
    x.addr  = {16'h4000, 16'($urandom_range(0, 65535))};
    if ($urandom_range(0, 3) != 0 && x.size <= 3'd2)
      x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
    x.write  = 1'($urandom_range(0, 1));
    x.prot   = 4'($urandom_range(0, 15));
    x.wdata  = $urandom;
    x.waits  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 9)) : 8'($urandom_range(0, 3));
    x.slverr = ($urandom_range(0, 5) == 0);
    x.rdata  = $urandom;
    x.gap    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
    return x;
  endfunction

  // ---------------- AHB master driver ----------------
  task automatic drive_noise();
    HSEL   = 1'($urandom_range(0, 1));
    HTRANS = HSEL ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom_range(0, 3));
    HADDR  = $urandom;
    HSIZE  = 3'($urandom_range(0, 7));
    HWRITE = 1'($urandom_range(0, 1));
    HPROT  = 4'($urandom_range(0, 15));
  endtask

  task automatic run_stim();
    int    idx = 0;
    int    gap_left = 0;
    int    cyc = 0;
    logic  hr;
    logic  a_valid = 1'b0;
    xfer_t a;
    while ((idx < stim_q.size() || a_valid || exp_q.size() != 0 || apb_exp_q.size() != 0)
           && cyc < 20000) begin
      @(negedge clk);
      hr = HREADYOUT;
      @(posedge clk);
      #1;
      cyc++;
      if (hr) begin
        if (a_valid) begin
          // address phase ended at this edge: now in data phase
          exp_q.push_back(exp_ahb(a));
          HWDATA  = a.wdata;
          a_valid = 1'b0;
        end
        if (gap_left > 0) begin
          gap_left--;
        end else if (idx < stim_q.size()) begin
          a = stim_q[idx];
          idx++;
          a_valid  = 1'b1;
          gap_left = int'(a.gap);
          if (!misaligned(a)) begin
            beh_q.push_back(a);
            apb_exp_q.push_back({a.addr[15:0], a.write, exp_strb(a), exp_prot(a), a.wdata});
          end
        end
        if (a_valid) begin
          HSEL   = 1'b1;
          HTRANS = {1'b1, 1'($urandom_range(0, 1))};
          HADDR  = a.addr;
          HSIZE  = a.size;
          HWRITE = a.write;
          HPROT  = a.prot;
        end else begin
          drive_noise();
        end
      end
    end
    if (cyc >= 20000) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_stim_timeout: got %0d cycles expected completion", cyc);
    end
    stim_q.delete();
  endtask

  // ---------------- APB slave model ----------------
  initial begin : apb_slave
    xfer_t cur;
    int    s_left;
    logic  s_active;
    s_active = 1'b0;
    s_left   = 0;
    cur      = '0;
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        s_active = 1'b0;
        PREADY   = 1'b0;
        PSLVERR  = 1'b0;
      end else if (PSEL && PENABLE) begin
        if (!s_active) begin
          if (beh_q.size() == 0) begin
            cur = '0;
          end else begin
            cur = beh_q.pop_front();
          end
          s_left   = int'(cur.waits);
          s_active = 1'b1;
        end
        if (s_left > 0) begin
          PREADY  = 1'b0;
          PSLVERR = 1'($urandom_range(0, 1));
          PRDATA  = $urandom;
          s_left--;
        end else begin
          PREADY   = 1'b1;
          PSLVERR  = cur.slverr;
          PRDATA   = cur.rdata;
          s_active = 1'b0;
        end
      end else begin
        // outside ACCESS the response lines are don't-care
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end
    end
  end

  // ---------------- AHB response monitor ----------------
  initial begin : ahb_monitor
    logic [41:0] e;
    int          low_cnt;
    logic        prev_resp;
    logic        prev_rdy;
    low_cnt   = 0;
    prev_resp = 1'b0;
    prev_rdy  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst || mon_hold) begin
        low_cnt   = 0;
        prev_resp = 1'b0;
        prev_rdy  = 1'b1;
      end else begin
        if (!PSEL) check("hrdata_zero_outside_access", HRDATA, 32'h0);
        if (exp_q.size() == 0) begin
          check("idle_ready_okay", {HREADYOUT, HRESP}, 2'b10);
          check("idle_no_apb", PSEL, 1'b0);
        end else if (!HREADYOUT) begin
          low_cnt++;
        end else begin
          e = exp_q.pop_front();
          check("ahb_wait_states", low_cnt, e[7:0]);
          check("ahb_hresp", HRESP, e[41]);
          if (e[41]) check("ahb_error_first_cycle", {prev_resp, prev_rdy}, 2'b10);
          else if (e[40]) check("ahb_hrdata", HRDATA, e[39:8]);
          low_cnt = 0;
        end
        prev_resp = HRESP;
        prev_rdy  = HREADYOUT;
      end
    end
  end

  // ---------------- APB request monitor ----------------
  initial begin : apb_monitor
    logic [55:0]        e;
    logic               prev_psel;
    logic               prev_en;
    logic               prev_done;
    logic [PADDR_W-1:0] prev_paddr;
    prev_psel  = 1'b0;
    prev_en    = 1'b0;
    prev_done  = 1'b0;
    prev_paddr = '0;
    forever begin
      @(negedge clk);
      if (rst || mon_hold) begin
        prev_psel = 1'b0;
        prev_en   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (PENABLE && !PSEL) check("apb_penable_without_psel", PSEL, 1'b1);
        if (prev_done) check("apb_penable_drops_after_access", PENABLE, 1'b0);
        if (PSEL && PENABLE && !prev_en)
          check("apb_setup_before_access", {prev_psel, prev_en, prev_paddr}, {1'b1, 1'b0, PADDR});
        if (PSEL && PENABLE && PREADY) begin
          if (apb_exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL apb_unexpected_access: got paddr %0h expected no access", PADDR);
          end else begin
            e = apb_exp_q.pop_front();
            check("apb_paddr", PADDR, e[55:40]);
            check("apb_pwrite", PWRITE, e[39]);
            check("apb_pstrb", PSTRB, e[38:35]);
            check("apb_pprot", PPROT, e[34:32]);
            if (e[39]) check("apb_pwdata", PWDATA, e[31:0]);
          end
        end
        prev_done  = PSEL && PENABLE && PREADY;
        prev_psel  = PSEL;
        prev_en    = PENABLE;
        prev_paddr = PADDR;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    xfer_t x;
    rst    = 1'b1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'h0;
    HSIZE  = 3'd0;
    HWRITE = 1'b0;
    HPROT  = 4'h0;
    HWDATA = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_idle", dbg_state, 3'd0);
    check("reset_psel", PSEL, 1'b0);
    check("reset_penable", PENABLE, 1'b0);
    check("reset_pwrite", PWRITE, 1'b0);
    check("reset_paddr", PADDR, 16'h0);
    check("reset_pstrb", PSTRB, 4'h0);
    check("reset_pprot", PPROT, 3'h0);
    check("reset_hreadyout", HREADYOUT, 1'b1);
    check("reset_hresp", HRESP, 1'b0);
    check("reset_hrdata", HRDATA, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // directed transfers, then random traffic
    stim_q.push_back(mk(32'h4000_0010, 3'd2, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1));
    stim_q.push_back(mk(32'h4000_0020, 3'd2, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1));
    stim_q.push_back(mk(32'h4000_0003, 3'd0, 1'b1, 32'hAA00_0000, 0, 1'b0, 32'h0, 0));
    stim_q.push_back(mk(32'h4000_0002, 3'd1, 1'b1, 32'hBBCC_0000, 1, 1'b0, 32'h0, 1));
    stim_q.push_back(mk(32'h4000_0030, 3'd2, 1'b0, 32'h0, 0, 1'b1, 32'h5555_AAAA, 1));
    stim_q.push_back(mk(32'h4000_0002, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0));
    stim_q.push_back(mk(32'h4000_0044, 3'd2, 1'b0, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 1));
    for (int i = 0; i < 200; i++) stim_q.push_back(rand_xfer());
    run_stim();

    // asynchronous reset in the middle of a stalled ACCESS
    mon_hold = 1'b1;
    @(posedge clk);
    #1;
    x = mk(32'h4000_0040, 3'd2, 1'b0, 32'h0, 8, 1'b0, 32'h0, 0);
    beh_q.push_back(x);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = x.addr; HSIZE = x.size; HWRITE = 1'b0; HPROT = x.prot;
    @(posedge clk);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge clk);
    #3;
    check("pre_reset_in_access", {PSEL, PENABLE, HREADYOUT}, 3'b110);
    rst = 1'b1;
    #1;
    check("mid_reset_psel_penable", {PSEL, PENABLE}, 2'b00);
    check("mid_reset_hreadyout_hresp", {HREADYOUT, HRESP}, 2'b10);
    check("mid_reset_hrdata", HRDATA, 32'h0);
    check("mid_reset_paddr_pstrb", {PADDR, PSTRB}, 20'h0);
    beh_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_hold = 1'b0;

    // traffic after reset must start with a clean SETUP
    stim_q.push_back(mk(32'h4000_0050, 3'd2, 1'b1, 32'hCAFE_0001, 0, 1'b0, 32'h0, 0));
    stim_q.push_back(mk(32'h4000_0056, 3'd1, 1'b0, 32'h0, 1, 1'b0, 32'h7777_8888, 1));
    for (int i = 0; i < 20; i++) stim_q.push_back(rand_xfer());
    run_stim();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
